// File: rtl/alu_resp_packer_if.sv
// ---------------------------------------------------------------------------
// alu_resp_packer_if
// Bundles the signals between the ALU command FSM, the response packer and
// the uart_tx byte stream.
//   s_valid_i / s_ready_o    word handshake from the ALU FSM
//   s_opcode_i, s_result_i   opcode and result word being handed over
//   m_axis_tdata/tvalid      byte stream towards uart_tx
//   m_axis_tready            uart_tx accepts the current byte
//   busy_o                   a frame is in progress
// Modports:
//   master  the packer itself, which drives the byte stream
//   slave   the surrounding environment (ALU FSM + uart_tx)
// ---------------------------------------------------------------------------
interface alu_resp_packer_if #(
  parameter int RESULT_W = 32
);
  logic                s_valid_i;
  logic                s_ready_o;
  logic [7:0]          s_opcode_i;
  logic [RESULT_W-1:0] s_result_i;
  logic [7:0]          m_axis_tdata;
  logic                m_axis_tvalid;
  logic                m_axis_tready;
  logic                busy_o;

  modport master (
    input  s_valid_i, s_opcode_i, s_result_i, m_axis_tready,
    output s_ready_o, m_axis_tdata, m_axis_tvalid, busy_o
  );

  modport slave (
    output s_valid_i, s_opcode_i, s_result_i, m_axis_tready,
    input  s_ready_o, m_axis_tdata, m_axis_tvalid, busy_o
  );
endinterface

// File: rtl/alu_resp_packer.sv
// ---------------------------------------------------------------------------
// alu_resp_packer
// Takes one opcode + result word per handshake and serialises it as the frame
//   OPC, LEN(=N), D0..D(N-1) (result LSB first), CHK
// on an AXI-stream byte master, where CHK is the XOR of every preceding byte.
// The word is held until the last byte has been accepted, so a busy UART
// never loses a result.
// Ports:
//   clk   system clock
//   rst   synchronous reset, active-high
//   bus   alu_resp_packer_if.master (word input, byte stream output, busy)
// Parameter:
//   RESULT_W  result width, multiple of 8 in 8..64 (N = RESULT_W/8 bytes)
// ---------------------------------------------------------------------------
module alu_resp_packer #(
  parameter int RESULT_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  alu_resp_packer_if.master  bus
);

  localparam int N     = RESULT_W / 8;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  localparam logic [7:0]       LEN_BYTE = 8'(N);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_OPC  = 3'd1,
    ST_LEN  = 3'd2,
    ST_DATA = 3'd3,
    ST_CHK  = 3'd4
  } state_t;

  state_t              state_q;
  logic                tvalid_q;
  logic [7:0]          tdata_q;
  logic                busy_q;
  logic [7:0]          chk_q;
  logic [IDX_W-1:0]    idx_q;
  // Result bytes still to be sent; the next D byte is always in [7:0].
  logic [RESULT_W-1:0] shift_q;
  logic                xfer;

  assign xfer = tvalid_q & bus.m_axis_tready;

  // Ready is the only output not taken straight from a flop: it must drop in
  // the very cycle rst is high.
  assign bus.s_ready_o     = (state_q == ST_IDLE) && !rst;
  assign bus.m_axis_tdata  = tdata_q;
  assign bus.m_axis_tvalid = tvalid_q;
  assign bus.busy_o        = busy_q;

  // Frame sequencer: state, byte register, running checksum and data index.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      tvalid_q <= 1'b0;
      tdata_q  <= 8'h00;
      busy_q   <= 1'b0;
      chk_q    <= 8'h00;
      idx_q    <= '0;
      shift_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // Inputs are only looked at here, so X on them elsewhere is harmless.
          if (bus.s_valid_i) begin
            shift_q  <= bus.s_result_i;
            tdata_q  <= bus.s_opcode_i;
            chk_q    <= bus.s_opcode_i ^ LEN_BYTE;
            idx_q    <= '0;
            tvalid_q <= 1'b1;
            busy_q   <= 1'b1;
            state_q  <= ST_OPC;
          end
        end

        ST_OPC: begin
          if (xfer) begin
            tdata_q <= LEN_BYTE;
            state_q <= ST_LEN;
          end
        end

        ST_LEN: begin
          if (xfer) begin
            tdata_q <= shift_q[7:0];
            chk_q   <= chk_q ^ shift_q[7:0];
            shift_q <= shift_q >> 4'd8;
            idx_q   <= '0;
            state_q <= ST_DATA;
          end
        end

        ST_DATA: begin
          if (xfer) begin
            if (idx_q == LAST_IDX) begin
              // Every D byte was folded in when loaded, so chk_q is final.
              tdata_q <= chk_q;
              idx_q   <= '0;
              state_q <= ST_CHK;
            end else begin
              tdata_q <= shift_q[7:0];
              chk_q   <= chk_q ^ shift_q[7:0];
              shift_q <= shift_q >> 4'd8;
              idx_q   <= idx_q + IDX_W'(1);
            end
          end
        end

        ST_CHK: begin
          if (xfer) begin
            tvalid_q <= 1'b0;
            busy_q   <= 1'b0;
            tdata_q  <= 8'h00;
            chk_q    <= 8'h00;
            state_q  <= ST_IDLE;
          end
        end

        default: begin
          state_q  <= ST_IDLE;
          tvalid_q <= 1'b0;
          tdata_q  <= 8'h00;
          busy_q   <= 1'b0;
          chk_q    <= 8'h00;
          idx_q    <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_resp_packer.sv
module tb_alu_resp_packer;

  logic clk;
  logic rst;

  alu_resp_packer_if #(.RESULT_W(32)) if32 ();
  alu_resp_packer_if #(.RESULT_W(8))  if8  ();

  alu_resp_packer #(.RESULT_W(32)) dut32 (.clk(clk), .rst(rst), .bus(if32.master));
  alu_resp_packer #(.RESULT_W(8))  dut8  (.clk(clk), .rst(rst), .bus(if8.master));

  int checks = 0;
  int errors = 0;

  // Expected frame bytes, pushed when a word is handed over.
  logic [7:0] q32[$];
  logic [7:0] q8[$];

  // tready drive mode for dut32: 0 = held, 1 = pattern 1,0,0, 2 = random
  int rdy_mode = 0;
  int pat_cnt  = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void push_byte(input bit to8, input logic [7:0] b);
    if (to8) q8.push_back(b);
    else     q32.push_back(b);
  endfunction

  function automatic void push_frame(input bit to8, input logic [7:0] opc,
                                     input logic [63:0] res, input int n);
    logic [7:0] chk;
    logic [7:0] b;
    chk = opc ^ 8'(n);
    push_byte(to8, opc);
    push_byte(to8, 8'(n));
    for (int i = 0; i < n; i++) begin
      b = res[8*i +: 8];
      chk = chk ^ b;
      push_byte(to8, b);
    end
    push_byte(to8, chk);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    case (rdy_mode)
      1: begin
        if32.m_axis_tready = (pat_cnt == 0);
        pat_cnt = (pat_cnt == 2) ? 0 : pat_cnt + 1;
      end
      2: if32.m_axis_tready = 1'($urandom_range(0, 1));
      default: ;
    endcase
  endtask

  task automatic send32(input logic [7:0] opc, input logic [31:0] res);
    int w;
    if32.s_valid_i  = 1'b1;
    if32.s_opcode_i = opc;
    if32.s_result_i = res;
    w = 0;
    while (!if32.s_ready_o && w < 500) begin
      tick();
      w++;
    end
    if (w >= 500) begin
      check("accept_timeout", if32.s_ready_o, 1'b1);
    end else begin
      // The previous frame must be completely drained before a new word is taken.
      check("no_overlap", q32.size(), 0);
      push_frame(1'b0, opc, {32'h0, res}, 4);
    end
    tick();
    if32.s_valid_i  = 1'b0;
    if32.s_opcode_i = 'x;
    if32.s_result_i = 'x;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while ((q32.size() != 0 || q8.size() != 0) && w < 3000) begin
      tick();
      w++;
    end
    check("drain_q32", q32.size(), 0);
    check("drain_q8", q8.size(), 0);
  endtask

  // Byte scoreboard and AXI stability monitor for the 32-bit instance.
  initial begin
    bit         stall = 1'b0;
    logic [7:0] last  = 8'h00;
    logic [7:0] exp;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall = 1'b0;
      end else begin
        if (stall) begin
          check("stall_valid32", if32.m_axis_tvalid, 1'b1);
          check("stall_data32", if32.m_axis_tdata, last);
        end
        check("busy32", if32.busy_o, if32.m_axis_tvalid);
        if (if32.m_axis_tvalid === 1'b1 && if32.m_axis_tready === 1'b1) begin
          check("sb_nonempty32", q32.size() != 0, 1'b1);
          if (q32.size() != 0) begin
            exp = q32.pop_front();
            check("byte32", if32.m_axis_tdata, exp);
          end
        end
        stall = (if32.m_axis_tvalid === 1'b1) && (if32.m_axis_tready !== 1'b1);
        last  = if32.m_axis_tdata;
      end
    end
  end

  // Byte scoreboard for the 8-bit instance.
  initial begin
    logic [7:0] exp;
    forever begin
      @(negedge clk);
      if (!rst && if8.m_axis_tvalid === 1'b1 && if8.m_axis_tready === 1'b1) begin
        check("sb_nonempty8", q8.size() != 0, 1'b1);
        if (q8.size() != 0) begin
          exp = q8.pop_front();
          check("byte8", if8.m_axis_tdata, exp);
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    if32.s_valid_i     = 1'b0;
    if32.s_opcode_i    = 8'h00;
    if32.s_result_i    = 32'h0;
    if32.m_axis_tready = 1'b1;
    if8.s_valid_i      = 1'b0;
    if8.s_opcode_i     = 8'h00;
    if8.s_result_i     = 8'h00;
    if8.m_axis_tready  = 1'b1;

    // Reset state
    tick();
    tick();
    check("rst_ready", if32.s_ready_o, 1'b0);
    check("rst_tvalid", if32.m_axis_tvalid, 1'b0);
    check("rst_tdata", if32.m_axis_tdata, 8'h00);
    check("rst_busy", if32.busy_o, 1'b0);
    check("rst_tvalid8", if8.m_axis_tvalid, 1'b0);
    tick();
    rst = 1'b0;
    #1;
    check("post_rst_ready", if32.s_ready_o, 1'b1);
    check("post_rst_ready8", if8.s_ready_o, 1'b1);

    // 1: single frame, tready held high -> 01 04 78 56 34 12 0D back to back
    send32(8'h01, 32'h12345678);
    for (int i = 0; i < 7; i++) begin
      check("t1_ready_low", if32.s_ready_o, 1'b0);
      check("t1_valid", if32.m_axis_tvalid, 1'b1);
      tick();
    end
    check("t1_ready_back", if32.s_ready_o, 1'b1);
    check("t1_idle", if32.m_axis_tvalid, 1'b0);
    check("t1_drained", q32.size(), 0);

    // 2: same frame with tready toggling 1,0,0,...
    rdy_mode = 1;
    pat_cnt  = 0;
    send32(8'h01, 32'h12345678);
    drain();
    rdy_mode = 0;
    if32.m_axis_tready = 1'b1;

    // 3: back-to-back words; the second waits for the first CHK
    send32(8'h02, 32'hFFFFFFFF);
    send32(8'h03, 32'h00000000);
    drain();

    // 4: reset during D1 abandons the frame
    send32(8'h11, 32'hCAFEBABE);
    tick();
    tick();
    tick();
    check("t4_d1", if32.m_axis_tdata, 8'hBA);
    rst = 1'b1;
    #1;
    check("t4_ready_in_rst", if32.s_ready_o, 1'b0);
    tick();
    rst = 1'b0;
    #1;
    check("t4_tvalid", if32.m_axis_tvalid, 1'b0);
    check("t4_busy", if32.busy_o, 1'b0);
    check("t4_ready", if32.s_ready_o, 1'b1);
    q32.delete();
    send32(8'h22, 32'h0BADF00D);
    drain();

    // 5: RESULT_W=8 instance -> A5 01 3C 98
    if8.s_valid_i  = 1'b1;
    if8.s_opcode_i = 8'hA5;
    if8.s_result_i = 8'h3C;
    check("t5_ready", if8.s_ready_o, 1'b1);
    push_frame(1'b1, 8'hA5, 64'h3C, 1);
    tick();
    if8.s_valid_i  = 1'b0;
    if8.s_opcode_i = 'x;
    if8.s_result_i = 'x;
    drain();
    tick();
    check("t5_idle", if8.m_axis_tvalid, 1'b0);

    // 6: random words with random tready
    rdy_mode = 2;
    for (int f = 0; f < 1000; f++) begin
      send32(8'($urandom), 32'($urandom));
    end
    drain();
    rdy_mode = 0;
    if32.m_axis_tready = 1'b1;
    tick();
    check("t6_idle", if32.m_axis_tvalid, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
